inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Program sequencer for the NECPU instruction ROM.
- Owns the PC and drives the ROM address; the ROM returns the word combinationally in the same cycle.
- Registers each fetched word into a one-entry valid/ready output stage for decode.
- Accepts PC redirects from execute (BEQ/BNE skip, JMP target), flushes the output stage, and stops at the end of the program.

Parameters:
- RESET_PC, 0: PC loaded on reset.
- PROG_LEN, 11: first PC outside the program. Fetching stops when pc >= PROG_LEN (unsigned).
- ADDR_W, 32: PC / ROM address width.
- INST_W, 32: instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  run enable. Low pauses fetching; the output stage still drains.
- rom_addr  out  ADDR_W  ROM address, always equal to the pc register.
- rom_inst  in  INST_W  ROM data for rom_addr, same cycle.
- inst_out  out  INST_W  registered instruction to decode.
- inst_pc  out  ADDR_W  PC of inst_out.
- inst_valid  out  1  inst_out/inst_pc hold a valid instruction.
- inst_ready  in  1  decode accepts inst_out this cycle.
- redirect_valid  in  1  execute requests a PC change.
- redirect_pc  in  ADDR_W  new PC: branch pc+2 for a taken skip, or R[rd] for JMP.
- done  out  1  program finished and output stage empty.
- issue_count  out  32  number of accepted handshakes.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pc=RESET_PC, state=IDLE.
  - inst_valid=0, inst_out=0, inst_pc=0, done=0, issue_count=0.
  - Reset asserted mid-operation overrides everything else that cycle.
- Handshake:
  - A transfer occurs when inst_valid && inst_ready.
  - inst_out and inst_pc stay stable while inst_valid=1 and inst_ready=0.
  - slot_free = !inst_valid || inst_ready.
- States:
  - IDLE: outputs idle. Go to RUN when en=1.
  - RUN: when en && slot_free && pc < PROG_LEN (fetch cycle):
    - inst_out<=rom_inst, inst_pc<=pc, inst_valid<=1, pc<=pc+1.
    - Throughput is one instruction per cycle; latency is 1 cycle from rom_addr to inst_valid.
    - When pc >= PROG_LEN, go to DRAIN and perform no capture.
    - When en=0, perform no capture. A pending transfer still clears inst_valid.
  - DRAIN: no fetch. Go to DONE once inst_valid=0, or once a transfer occurs this cycle.
  - DONE: done=1, pc holds, no fetch.
- Redirect (highest priority after reset), in RUN, DRAIN or DONE:
  - pc<=redirect_pc and inst_valid<=0 (flush). No capture that cycle, even if slot_free.
  - A transfer in the same cycle still counts, since decode consumed the word.
  - Next state is RUN and done<=0.
  - Redirect in IDLE only loads pc.
- Arithmetic:
  - pc+1 wraps modulo 2^ADDR_W.
  - issue_count increments on each transfer and saturates at 0xFFFFFFFF.
- Simultaneous events:
  - Transfer + fetch in the same cycle keeps inst_valid=1 (back-to-back).
  - Transfer with no fetch sets inst_valid<=0.
  - en falling mid-stall: the held word remains valid.

Test Plan:
- Reset, en=1, inst_ready=1, PROG_LEN=11 -> inst_pc sequence 0..10 on consecutive cycles, then done=1 two cycles after inst_pc=10 is accepted, issue_count=11.
- inst_ready low for 3 cycles while inst_pc=4 -> inst_out/inst_pc stay at pc 4, rom_addr holds 5, no count change. On release, 5 follows the next cycle.
- redirect_valid with redirect_pc=10 while inst_pc=8 is valid and inst_ready=1 -> 8 counted, inst_valid=0 next cycle, then inst_pc=10. Word 9 is never issued.
- JMP redirect_pc=4 after done=1 -> done drops, fetch resumes at pc 4 and runs 4..10, done reasserts.
- rst_n=0 for one cycle mid-stream at pc=6 -> next cycle pc=0, inst_valid=0, issue_count=0, state IDLE.
- en=0 at pc=3 for 2 cycles with inst_ready=1 -> the held word drains once, no new fetch, pc stays 3. Fetch resumes when en=1.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Program sequencer for the NECPU instruction ROM. Holds the PC, presents it
// as the ROM address, and registers each fetched word into a one-entry
// valid/ready stage for decode. Handles execute redirects and end of program.
module inst_fetch_ctrl #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [ADDR_W-1:0]  PROG_LEN = ADDR_W'(11)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              done,
  output logic [31:0]       issue_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INST_W-1:0]   inst_q;
  logic [ADDR_W-1:0]   ipc_q;
  logic                valid_q;
  logic                done_q;
  logic [31:0]         cnt_q;
  logic [31:0]         cnt_d;
  logic                transfer;
  logic                slot_free;
  logic                in_prog;

  // Handshake qualifiers and saturating issue counter next value.
  always_comb begin
    transfer  = valid_q && inst_ready;
    slot_free = !valid_q || inst_ready;
    in_prog   = (pc_q < PROG_LEN);
    cnt_d     = cnt_q;
    if (transfer && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Sequencer FSM: PC, output stage, done flag and issue counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // A transfer is counted even when a redirect flushes the stage.
      cnt_q <= cnt_d;
      if (redirect_valid) begin
        pc_q <= redirect_pc;
        if (state_q != S_IDLE) begin
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_RUN;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (en) begin
              state_q <= S_RUN;
            end
          end
          S_RUN: begin
            if (!in_prog) begin
              state_q <= S_DRAIN;
              if (transfer) begin
                valid_q <= 1'b0;
              end
            end else if (en && slot_free) begin
              inst_q  <= rom_inst;
              ipc_q   <= pc_q;
              valid_q <= 1'b1;
              pc_q    <= pc_q + ADDR_W'(1);
            end else if (transfer) begin
              valid_q <= 1'b0;
            end
          end
          S_DRAIN: begin
            if (transfer) begin
              valid_q <= 1'b0;
            end
            if (!valid_q || transfer) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
          S_DONE: begin
            done_q <= 1'b1;
            if (transfer) begin
              valid_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rom_addr    = pc_q;
  assign inst_out    = inst_q;
  assign inst_pc     = ipc_q;
  assign inst_valid  = valid_q;
  assign done        = done_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: a combinational ROM model, a
// scoreboard of expected issued PCs checked on every handshake, and directed
// scenarios for stall, redirect, restart after done, reset and en pause.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        done;
  logic [31:0] issue_count;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] sb_q[$];

  inst_fetch_ctrl #(
    .ADDR_W  (32),
    .INST_W  (32),
    .RESET_PC(32'd0),
    .PROG_LEN(32'd11)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .done          (done),
    .issue_count   (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {16'hC0DE, a[15:0]} ^ 32'h0000_5A00;
  endfunction

  assign rom_inst = rom_f(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every handshake must match the next expected PC and word.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        check("sb_pc", inst_pc, sb_q[0]);
        check("sb_inst", inst_out, rom_f(sb_q[0]));
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int unsigned lo, input int unsigned hi);
    for (int unsigned p = lo; p <= hi; p++) sb_q.push_back(32'(p));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input logic [31:0] pc, input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (inst_valid && inst_pc == pc) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 60; k++) begin
      if (done) break;
      tick();
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    en = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_out", inst_out, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", issue_count, 32'd0);
    check("rst_addr", rom_addr, 32'd0);

    // Full run at one instruction per cycle
    push_range(0, 10);
    rst_n = 1'b1;
    en = 1'b1;
    inst_ready = 1'b1;
    tick();
    check("idle_no_valid", 32'(inst_valid), 32'd0);
    tick();
    for (int unsigned i = 0; i <= 10; i++) begin
      check("seq_valid", 32'(inst_valid), 32'd1);
      check("seq_pc", inst_pc, 32'(i));
      tick();
    end
    check("end_valid", 32'(inst_valid), 32'd0);
    check("end_done_early", 32'(done), 32'd0);
    tick();
    check("end_done", 32'(done), 32'd1);
    check("end_cnt", issue_count, 32'd11);
    check("end_addr", rom_addr, 32'd11);
    tick();
    check("done_hold_addr", rom_addr, 32'd11);

    // Stall with inst_pc=4 held for three cycles
    do_reset();
    push_range(0, 10);
    wait_pc(32'd4, "stall_reach4");
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_pc", inst_pc, 32'd4);
      check("stall_out", inst_out, rom_f(32'd4));
      check("stall_addr", rom_addr, 32'd5);
      check("stall_cnt", issue_count, 32'd4);
    end
    inst_ready = 1'b1;
    tick();
    check("stall_rel_pc", inst_pc, 32'd5);
    check("stall_rel_cnt", issue_count, 32'd5);
    wait_done("stall_done");
    check("stall_cnt_end", issue_count, 32'd11);

    // Redirect to 10 while inst_pc=8 is accepted
    do_reset();
    push_range(0, 8);
    push_range(10, 10);
    wait_pc(32'd8, "redir_reach8");
    redirect_valid = 1'b1;
    redirect_pc = 32'd10;
    tick();
    redirect_valid = 1'b0;
    check("redir_flush", 32'(inst_valid), 32'd0);
    check("redir_addr", rom_addr, 32'd10);
    check("redir_cnt", issue_count, 32'd9);
    tick();
    check("redir_valid", 32'(inst_valid), 32'd1);
    check("redir_pc", inst_pc, 32'd10);
    wait_done("redir_done");
    check("redir_cnt_end", issue_count, 32'd10);

    // JMP to 4 after done
    push_range(4, 10);
    redirect_valid = 1'b1;
    redirect_pc = 32'd4;
    tick();
    redirect_valid = 1'b0;
    check("jmp_done_drop", 32'(done), 32'd0);
    check("jmp_addr", rom_addr, 32'd4);
    tick();
    check("jmp_pc", inst_pc, 32'd4);
    wait_done("jmp_done");
    check("jmp_cnt", issue_count, 32'd17);

    // Reset mid-stream at pc 6
    do_reset();
    push_range(0, 5);
    wait_pc(32'd6, "mid_reach6");
    rst_n = 1'b0;
    tick();
    check("mid_addr", rom_addr, 32'd0);
    check("mid_valid", 32'(inst_valid), 32'd0);
    check("mid_cnt", issue_count, 32'd0);
    check("mid_done", 32'(done), 32'd0);
    push_range(0, 10);
    rst_n = 1'b1;
    tick();
    check("mid_idle", 32'(inst_valid), 32'd0);
    tick();
    check("mid_first_pc", inst_pc, 32'd0);

    // en low for two cycles with pc=3
    wait_pc(32'd2, "en_reach2");
    check("en_addr3", rom_addr, 32'd3);
    en = 1'b0;
    tick();
    check("en_drain", 32'(inst_valid), 32'd0);
    check("en_addr_a", rom_addr, 32'd3);
    tick();
    check("en_addr_b", rom_addr, 32'd3);
    check("en_cnt", issue_count, 32'd3);
    en = 1'b1;
    tick();
    check("en_resume_pc", inst_pc, 32'd3);
    wait_done("en_done");
    check("en_cnt_end", issue_count, 32'd11);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
